// File: rtl/matrix_stream_loader_if.sv
// Stream-in / matrix-out bundle between an element producer, the loader and the
// matrix consumer. The loader takes the slave modport.
interface matrix_stream_loader_if #(
  parameter int unsigned M     = 4,
  parameter int unsigned N     = 4,
  parameter int unsigned nBits = 32
);
  logic                    start;
  logic [nBits-1:0]        in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [nBits*M*N-1:0]    matrix;
  logic                    matrix_valid;
  logic                    matrix_ack;

  modport master (
    output start,
    output in_data,
    output in_valid,
    output matrix_ack,
    input  in_ready,
    input  matrix,
    input  matrix_valid
  );

  modport slave (
    input  start,
    input  in_data,
    input  in_valid,
    input  matrix_ack,
    output in_ready,
    output matrix,
    output matrix_valid
  );
endinterface

// File: rtl/matrix_stream_loader.sv
// Packs row-major streamed elements into the flat selector matrix bus and holds
// the completed matrix with matrix_valid until the consumer acknowledges it.
module matrix_stream_loader #(
  parameter int unsigned M     = 4,
  parameter int unsigned N     = 4,
  parameter int unsigned nBits = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  matrix_stream_loader_if.slave    bus,
  output logic                     busy,
  output logic [nBits-1:0]         ipos,
  output logic [nBits-1:0]         jpos
);

  localparam int unsigned MatW = nBits * M * N;

  typedef enum logic [1:0] {StIdle, StLoad, StFull} state_e;

  state_e            state_q, state_d;
  logic [MatW-1:0]   matrix_q, matrix_d;
  logic [nBits-1:0]  ipos_q, ipos_d;
  logic [nBits-1:0]  jpos_q, jpos_d;
  logic              load_start;
  logic              last_elem;

  // Any start that lands the FSM in LOAD wipes the matrix and rewinds the cursor.
  assign load_start = bus.start &
                      ((state_q == StIdle) | (state_q == StLoad) |
                       ((state_q == StFull) & bus.matrix_ack));

  assign last_elem = (ipos_q == nBits'(M - 1)) && (jpos_q == nBits'(N - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = StLoad;
      end
      StLoad: begin
        if (!bus.start && bus.in_valid && last_elem) state_d = StFull;
      end
      StFull: begin
        if (bus.matrix_ack) state_d = bus.start ? StLoad : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.in_ready     = (state_q == StLoad);
    busy             = (state_q == StLoad);
    bus.matrix_valid = (state_q == StFull);
  end

  always_comb begin
    matrix_d = matrix_q;
    ipos_d   = ipos_q;
    jpos_d   = jpos_q;
    if (load_start) begin
      matrix_d = '0;
      ipos_d   = '0;
      jpos_d   = '0;
    end else if ((state_q == StLoad) && bus.in_valid) begin
      // Element (i,j) sits at the top of the bus for (0,0), descending row-major.
      for (int unsigned i = 0; i < M; i++) begin
        for (int unsigned j = 0; j < N; j++) begin
          if ((ipos_q == nBits'(i)) && (jpos_q == nBits'(j))) begin
            matrix_d[(M * N - 1 - (N * i + j)) * nBits +: nBits] = bus.in_data;
          end
        end
      end
      if (jpos_q == nBits'(N - 1)) begin
        jpos_d = '0;
        ipos_d = last_elem ? '0 : ipos_q + 1'b1;
      end else begin
        jpos_d = jpos_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      matrix_q <= '0;
      ipos_q   <= '0;
      jpos_q   <= '0;
    end else begin
      matrix_q <= matrix_d;
      ipos_q   <= ipos_d;
      jpos_q   <= jpos_d;
    end
  end

  assign bus.matrix = matrix_q;
  assign ipos       = ipos_q;
  assign jpos       = jpos_q;

endmodule
